check_collision: RTL and testbench
==================================

// Module: check_collision
// PURPOSE
//   Maze wall checker for sprite movement (Pac-Man / ghost controllers).
//   Given a sprite's current top-left position and intended direction, reports
//   whether a one-pixel step in that direction is legal, i.e. free of walls.
//   Movers step only when result=1 and re-pick a direction when result=0.
// PARAMETERS
//   SPRITE  16  sprite edge length in pixels (square box)
// PORTS
//   clk     in   1   system clock; single clock domain
//   rst     in   1   reset, synchronous, active-low
//   PacX    in   10  sprite top-left x, pixels (screen 640x480)
//   PacY    in   9   sprite top-left y, pixels
//   state   in   2   intended direction: 00 up, 01 down, 10 left, 11 right
//   result  out  1   1 = step is free, 0 = step blocked
// BEHAVIOUR
//   - Registered output: on each rising clk, result <= legal(PacX,PacY,state).
//     Latency is exactly 1 clk; no handshake; evaluated every cycle.
//   - Reset: on rising clk with rst=0, result <= 0; has priority over evaluation.
//     Reset mid-operation discards the pending evaluation.
//   - Probe position (nx,ny), computed 11-bit unsigned:
//     00: (x, y-1)  01: (x, y+1)  10: (x-1, y)  11: (x+1, y).
//     Underflow (x=0 left, y=0 up) is blocked. Overflow is blocked when
//     nx+SPRITE-1 > 639 or ny+SPRITE-1 > 479.
//   - Sprite box = [nx, nx+SPRITE-1] x [ny, ny+SPRITE-1].
//     Box overlaps wall [x0..x1]x[y0..y1] iff
//     nx<=x1 && nx+SPRITE-1>=x0 && ny<=y1 && ny+SPRITE-1>=y0. Bounds inclusive.
//   - legal = 1 iff no overflow/underflow and no overlap with any wall below.
//   - Fixed wall table (inclusive x0..x1, y0..y1):
//     W0 top     40..599,  40..55
//     W1 bottom  40..599, 424..439
//     W2 left    40..55,   40..439
//     W3 right  584..599,  40..439
//     W4        120..183, 120..183
//     W5        456..519, 120..183
//     W6        120..183, 296..359
//     W7        456..519, 296..359
//     W8        264..375, 184..199
//   - Spawn points (320,240) and (200,146) lie in free space.
//   - Combinational checks run in parallel, one comparator set per wall, then
//     OR-reduced. No internal state other than the result flop.
//   - Inputs may change every cycle. result always reflects inputs sampled at
//     the previous edge, including a direction change without a position change.
// TESTING
//   1. rst=0 for 2 clk at any position -> result=0; release -> valid next clk.
//   2. (320,240), state=11 -> result=1 one clk later; state=00 -> still 1.
//   3. (567,240) right -> 1 (box ends at x=583); (568,240) right -> 0 (hits W3).
//   4. (200,57) up -> 1; (200,56) up -> 0 (hits W0 at y=55).
//   5. (184,150) left -> 0 (hits W4); (184,150) right -> 1; state toggling
//      each cycle gives result alternating 0/1 with 1-clk lag.
//   6. (0,240) left -> 0 (underflow); (624,240) right -> 0 (overflow past 639).

Source files
------------

// File: rtl/check_collision_if.sv
// Sprite position/direction request and step-legal response between a mover
// and the wall checker.
interface check_collision_if;
    logic [9:0] PacX;
    logic [8:0] PacY;
    logic [1:0] state;
    logic       result;

    modport master (output PacX, output PacY, output state, input result);
    modport slave  (input PacX, input PacY, input state, output result);
endinterface

// File: rtl/check_collision.sv
// Maze wall checker: registers whether a one-pixel step of a SPRITE-sized box
// in the requested direction stays on screen and clear of every fixed wall.
module check_collision #(
    parameter int unsigned SPRITE = 16
) (
    input  logic                clk,
    input  logic                rst,
    check_collision_if.slave    bus
);
    localparam int unsigned NWALL = 9;

    typedef enum logic [1:0] {DirUp = 2'b00, DirDown = 2'b01, DirLeft = 2'b10, DirRight = 2'b11}
        dir_e;

    // Inclusive wall rectangles, in table order W0..W8.
    localparam logic [11:0] WALL_X0 [NWALL] = '{12'd40, 12'd40, 12'd40, 12'd584, 12'd120,
                                                12'd456, 12'd120, 12'd456, 12'd264};
    localparam logic [11:0] WALL_X1 [NWALL] = '{12'd599, 12'd599, 12'd55, 12'd599, 12'd183,
                                                12'd519, 12'd183, 12'd519, 12'd375};
    localparam logic [11:0] WALL_Y0 [NWALL] = '{12'd40, 12'd424, 12'd40, 12'd40, 12'd120,
                                                12'd120, 12'd296, 12'd296, 12'd184};
    localparam logic [11:0] WALL_Y1 [NWALL] = '{12'd55, 12'd439, 12'd439, 12'd439, 12'd183,
                                                12'd183, 12'd359, 12'd359, 12'd199};

    logic [10:0]      nx, ny;
    logic [11:0]      nx_end, ny_end;
    logic             underflow, overflow;
    logic [NWALL-1:0] hit;
    logic             legal;
    logic             result_q;

    always_comb begin
        nx        = {1'b0, bus.PacX};
        ny        = {2'b00, bus.PacY};
        underflow = 1'b0;
        unique case (dir_e'(bus.state))
            DirUp: begin
                underflow = (bus.PacY == 9'd0);
                ny        = {2'b00, bus.PacY} - 11'd1;
            end
            DirDown:  ny = {2'b00, bus.PacY} + 11'd1;
            DirLeft: begin
                underflow = (bus.PacX == 10'd0);
                nx        = {1'b0, bus.PacX} - 11'd1;
            end
            DirRight: nx = {1'b0, bus.PacX} + 11'd1;
            default: ;
        endcase

        // 12-bit box ends so the far edge cannot wrap before the bound test.
        nx_end   = {1'b0, nx} + 12'(SPRITE - 1);
        ny_end   = {1'b0, ny} + 12'(SPRITE - 1);
        overflow = (nx_end > 12'd639) || (ny_end > 12'd479);

        for (int i = 0; i < NWALL; i++) begin
            hit[i] = ({1'b0, nx} <= WALL_X1[i]) && (nx_end >= WALL_X0[i]) &&
                     ({1'b0, ny} <= WALL_Y1[i]) && (ny_end >= WALL_Y0[i]);
        end

        legal = !underflow && !overflow && !(|hit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= 1'b0;
        end else begin
            result_q <= legal;
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_check_collision.sv
// Directed-vector bench for check_collision with hand-computed expectations.
module tb_check_collision;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    check_collision_if bus ();

    check_collision #(.SPRITE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one request, let one edge sample it, then compare the registered result.
    task automatic step(input string tag, input int x, input int y, input logic [1:0] dir,
                        input logic exp);
        bus.PacX  = 10'(x);
        bus.PacY  = 9'(y);
        bus.state = dir;
        @(posedge clk);
        #1;
        check_bit(tag, bus.result, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.PacX  = 10'd320;
        bus.PacY  = 9'd240;
        bus.state = 2'b11;

        @(posedge clk); #1;
        check_bit("reset_c1", bus.result, 1'b0);
        @(posedge clk); #1;
        check_bit("reset_c2", bus.result, 1'b0);
        #3 rst = 1'b1;

        step("spawn_right",   320, 240, 2'b11, 1'b1);
        step("spawn_up",      320, 240, 2'b00, 1'b1);
        step("spawn_down",    320, 240, 2'b01, 1'b1);
        step("spawn2_left",   200, 146, 2'b10, 1'b1);
        step("w3_clear",      567, 240, 2'b11, 1'b1);
        step("w3_hit",        568, 240, 2'b11, 1'b0);
        step("w0_clear",      200,  57, 2'b00, 1'b1);
        step("w0_hit",        200,  56, 2'b00, 1'b0);
        step("w1_clear",      200, 407, 2'b01, 1'b1);
        step("w1_hit",        200, 408, 2'b01, 1'b0);
        step("w4_left",       184, 150, 2'b10, 1'b0);
        step("w4_right",      184, 150, 2'b11, 1'b1);

        for (int i = 0; i < 6; i++) begin
            step("toggle", 184, 150, (i % 2 == 0) ? 2'b10 : 2'b11,
                 (i % 2 == 0) ? 1'b0 : 1'b1);
        end

        step("x_underflow",     0, 240, 2'b10, 1'b0);
        step("x_overflow",    624, 240, 2'b11, 1'b0);
        step("y_underflow",   320,   0, 2'b00, 1'b0);
        step("y_overflow",    320, 464, 2'b01, 1'b0);
        step("w8_hit",        300, 200, 2'b00, 1'b0);

        // Mid-operation reset discards a legal pending evaluation.
        bus.PacX  = 10'd320;
        bus.PacY  = 9'd240;
        bus.state = 2'b11;
        rst       = 1'b0;
        @(posedge clk); #1;
        check_bit("reset_mid", bus.result, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_bit("after_reset", bus.result, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
